axis_frame_pacer: RTL and testbench
===================================

# axis_frame_pacer

Store-and-forward frame buffer in the 156.25 MHz `tx_clk_out` domain, directly upstream of the AXI-to-GMII converter. It accepts bursty, back-to-back 64-bit AXI-Stream beats from the 10G receive path, which has no backpressure. It releases only complete frames, one beat every `PACE_CYCLES` clocks, so the 125 MHz byte-serial GMII stage (8 bytes per 64 ns) is never overrun. Frames that do not fit are dropped whole and counted.

## Interface
Parameters:
- `ADDR_W`, 9: log2 of buffer depth in beats (512 beats = 4 KiB).
- `PACE_CYCLES`, 10: clocks between consecutive output beats; legal range 2..255.
- `IFG_CYCLES`, 24: minimum idle clocks after a frame's last output beat; legal range 0..255.

Ports:
- `tx_clk_out`, in, 1: clock, 156.25 MHz.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `s_axis_tvalid`, in, 1: input beat valid; no tready is provided.
- `s_axis_tdata`, in, 64: input data.
- `s_axis_tkeep`, in, 8: input byte enables.
- `s_axis_tlast`, in, 1: last beat of frame.
- `m_axis_tvalid`, out, 1: output beat valid, one-cycle pulse per beat.
- `m_axis_tdata`, out, 64: output data.
- `m_axis_tkeep`, out, 8: output byte enables.
- `m_axis_tlast`, out, 1: output last beat.
- `drop_cnt`, out, 16: frames dropped; saturates at 16'hFFFF.
- `frames_avail`, out, ADDR_W+1: number of committed frames not yet fully sent.

## Operation
- **Storage**
  - Simple dual-port RAM, 2^ADDR_W × 73 bits ({last, keep, data}), 1-cycle registered read.
  - Pointers are ADDR_W+1 bits: `wr_ptr` (speculative), `wr_commit`, `rd_ptr`.
  - Full when `wr_ptr - rd_ptr == 2^ADDR_W`; arithmetic is modulo 2^(ADDR_W+1), so wrap-around is natural.
- **Write side** (every cycle with `s_axis_tvalid`):
  - Not dropping and not full: write the beat at `wr_ptr`, then `wr_ptr++`.
  - Same, and `tlast`=1: `wr_commit <= wr_ptr+1` and `frames_avail` increments.
  - Not dropping and full: `wr_ptr <= wr_commit` (rollback) and the beat is discarded. If `tlast`=0, set `dropping`. `drop_cnt` increments once for this frame.
  - Dropping: discard the beat. A `tlast` beat clears `dropping`.
  - A frame larger than 2^ADDR_W beats is always dropped.
  - `tkeep` contents are stored unchanged and never inspected.
- **Read FSM**
  - IDLE: if `frames_avail != 0`, go to SEND with `pace_cnt = 0`.
  - SEND: when `pace_cnt == 0`, issue a RAM read at `rd_ptr`, `rd_ptr++`, reload `pace_cnt = PACE_CYCLES-1`. Otherwise decrement `pace_cnt`.
  - SEND, read data returning with last=1: `frames_avail` decrements. Go to GAP with `gap_cnt = IFG_CYCLES`, or straight to IDLE if `IFG_CYCLES == 0`.
  - GAP: decrement `gap_cnt`; go to IDLE when it reaches 0.
  - Output registers load the RAM read data and pulse `m_axis_tvalid` for one cycle. Between pulses, `m_axis_tdata`/`tkeep`/`tlast` hold their last values.
- **Simultaneous events**
  - Commit and decrement of `frames_avail` in the same cycle: net unchanged.
  - Write and read of the same address never overlap, because only committed beats are read.
  - The free-space check uses the current `rd_ptr`, so a same-cycle read does not free space until the next cycle.

## Timing
- Reset (async assert, sync release):
  - All outputs 0.
  - All pointers 0.
  - `dropping` = 0, FSM in IDLE, `drop_cnt` = 0.
  - A frame partially written or partially sent is lost; no output pulse follows reset.
- Latency: `tlast` sampled at edge E → `frames_avail` updates at E+1 → read issued at E+2 → first `m_axis_tvalid` high for the cycle after edge E+3. This assumes an empty buffer and the FSM in IDLE.
- Beat spacing inside a frame: exactly `PACE_CYCLES` clocks, rising edge to rising edge.
- Frame-to-frame: the next frame's first pulse comes no earlier than `IFG_CYCLES + 2` clocks after the previous `tlast` pulse.
- Throughput: at the default `PACE_CYCLES`=10, the output rate is 8 B / 64 ns, matching GMII at 1 Gb/s.

## Test plan
- **Single frame:** 3-beat frame, `tkeep` = FF, FF, 0F, input back-to-back. Required: 3 output pulses spaced 10 clocks apart; the first is 3 clocks after input `tlast`; `m_axis_tlast` is set on the third pulse only; data matches input.
- **Two back-to-back frames:** a 2-beat and a 1-beat frame with no input gap. Required: `frames_avail` peaks at 2; the second frame's first pulse comes at least 26 clocks after the first frame's `tlast` pulse.
- **Overflow drop:** `ADDR_W`=4; send a 10-beat frame, then immediately a 10-beat frame. Required: the first frame is output intact; the second is dropped with no output; `drop_cnt` = 1. A subsequent 4-beat frame is output correctly.
- **Oversize frame:** `ADDR_W`=4, 20-beat frame into an empty buffer. Required: `drop_cnt` = 1, no output pulses, pointers return to their pre-frame values.
- **Wrap-around:** 200 random frames of 1–60 beats with random gaps, `ADDR_W`=6. Required: the output stream equals the input stream minus dropped frames, in order. `drop_cnt` equals the scoreboard drop count. Beat spacing is always 10.
- **Reset mid-frame:** assert `rst_n`=0 while beat 2 of 5 is being output. Required: all outputs 0 immediately; after release, a new 1-beat frame is output exactly per the latency rule.

Source files
------------

// File: rtl/axis_frame_pacer.sv
// Store-and-forward frame buffer: accepts unthrottled AXI-Stream beats, releases only
// complete frames at one beat per PACE_CYCLES clocks, and drops (and counts) frames that do not fit.
module axis_frame_pacer #(
    parameter int ADDR_W      = 9,
    parameter int PACE_CYCLES = 10,
    parameter int IFG_CYCLES  = 24
) (
    input  logic              tx_clk_out,
    input  logic              rst_n,
    input  logic              s_axis_tvalid,
    input  logic [63:0]       s_axis_tdata,
    input  logic [7:0]        s_axis_tkeep,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    output logic [63:0]       m_axis_tdata,
    output logic [7:0]        m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic [15:0]       drop_cnt,
    output logic [ADDR_W:0]   frames_avail
);
    localparam int              DEPTH       = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [7:0]      PACE_RELOAD = 8'(PACE_CYCLES - 1);
    localparam logic [7:0]      IFG_LOAD    = 8'(IFG_CYCLES);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    logic [72:0]     mem [DEPTH];
    logic [72:0]     rd_data_q;
    logic            rd_valid_q;

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0] wr_commit_q, wr_commit_d;
    logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0] frames_avail_q, frames_avail_d;
    logic [ADDR_W:0] used;
    logic            dropping_q, dropping_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    state_t          state_q, state_d;
    logic [7:0]      pace_cnt_q, pace_cnt_d;
    logic [7:0]      gap_cnt_q, gap_cnt_d;
    logic            wr_en, rd_en, commit, release_frame, full;

    logic            m_tvalid_q;
    logic [63:0]     m_tdata_q;
    logic [7:0]      m_tkeep_q;
    logic            m_tlast_q;

    // Occupancy is measured against the current read pointer only, so a read in
    // this cycle frees its slot from the next cycle on.
    assign used = wr_ptr_q - rd_ptr_q;
    assign full = (used == FULL_LEVEL);

    always_comb begin
        wr_en       = 1'b0;
        commit      = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        dropping_d  = dropping_q;
        drop_cnt_d  = drop_cnt_q;
        if (s_axis_tvalid) begin
            if (dropping_q) begin
                if (s_axis_tlast) dropping_d = 1'b0;
            end else if (full) begin
                wr_ptr_d   = wr_commit_q;
                dropping_d = ~s_axis_tlast;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end else begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (s_axis_tlast) begin
                    commit      = 1'b1;
                    wr_commit_d = wr_ptr_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        pace_cnt_d    = pace_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        rd_ptr_d      = rd_ptr_q;
        rd_en         = 1'b0;
        release_frame = 1'b0;
        case (state_q)
            IDLE: begin
                if (frames_avail_q != '0) begin
                    state_d    = SEND;
                    pace_cnt_d = '0;
                end
            end
            SEND: begin
                if (rd_valid_q && rd_data_q[72]) begin
                    release_frame = 1'b1;
                    if (IFG_CYCLES == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d   = GAP;
                        gap_cnt_d = IFG_LOAD;
                    end
                end else if (pace_cnt_q == '0) begin
                    rd_en      = 1'b1;
                    rd_ptr_d   = rd_ptr_q + 1'b1;
                    pace_cnt_d = PACE_RELOAD;
                end else begin
                    pace_cnt_d = pace_cnt_q - 8'd1;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - 8'd1;
                if (gap_cnt_q <= 8'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case ({commit, release_frame})
            2'b10:   frames_avail_d = frames_avail_q + 1'b1;
            2'b01:   frames_avail_d = frames_avail_q - 1'b1;
            default: frames_avail_d = frames_avail_q;
        endcase
    end

    // Buffer storage has no reset; rd_valid_q gates every use of the read data.
    always_ff @(posedge tx_clk_out) begin
        if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (rd_en) rd_data_q <= mem[rd_ptr_q[ADDR_W-1:0]];
    end

    always_ff @(posedge tx_clk_out or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q       <= '0;
            wr_commit_q    <= '0;
            rd_ptr_q       <= '0;
            frames_avail_q <= '0;
            dropping_q     <= 1'b0;
            drop_cnt_q     <= '0;
            state_q        <= IDLE;
            pace_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            rd_valid_q     <= 1'b0;
            m_tvalid_q     <= 1'b0;
            m_tdata_q      <= '0;
            m_tkeep_q      <= '0;
            m_tlast_q      <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            wr_commit_q    <= wr_commit_d;
            rd_ptr_q       <= rd_ptr_d;
            frames_avail_q <= frames_avail_d;
            dropping_q     <= dropping_d;
            drop_cnt_q     <= drop_cnt_d;
            state_q        <= state_d;
            pace_cnt_q     <= pace_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            rd_valid_q     <= rd_en;
            m_tvalid_q     <= rd_valid_q;
            if (rd_valid_q) {m_tlast_q, m_tkeep_q, m_tdata_q} <= rd_data_q;
        end
    end

    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tkeep  = m_tkeep_q;
    assign m_axis_tlast  = m_tlast_q;
    assign drop_cnt      = drop_cnt_q;
    assign frames_avail  = frames_avail_q;

endmodule

// File: tb/tb_axis_frame_pacer.sv
// Self-checking bench for axis_frame_pacer: directed vector table, multi-cycle corner
// sequences on a 16-beat instance, and a scoreboarded random stream on a 64-beat instance.
`timescale 1ns/100ps
module tb_axis_frame_pacer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sValid = 1'b0;
    logic [63:0] sData = '0;
    logic [7:0]  sKeep = '0;
    logic        sLast = 1'b0;

    logic        m4Valid, m4Last, m6Valid, m6Last;
    logic [63:0] m4Data, m6Data;
    logic [7:0]  m4Keep, m6Keep;
    logic [15:0] drop4, drop6;
    logic [4:0]  avail4;
    logic [6:0]  avail6;

    axis_frame_pacer #(.ADDR_W(4)) dut4 (
        .tx_clk_out(clk), .rst_n(rst_n),
        .s_axis_tvalid(sValid), .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
        .m_axis_tvalid(m4Valid), .m_axis_tdata(m4Data), .m_axis_tkeep(m4Keep), .m_axis_tlast(m4Last),
        .drop_cnt(drop4), .frames_avail(avail4)
    );

    axis_frame_pacer #(.ADDR_W(6)) dut6 (
        .tx_clk_out(clk), .rst_n(rst_n),
        .s_axis_tvalid(sValid), .s_axis_tdata(sData), .s_axis_tkeep(sKeep), .s_axis_tlast(sLast),
        .m_axis_tvalid(m6Valid), .m_axis_tdata(m6Data), .m_axis_tkeep(m6Keep), .m_axis_tlast(m6Last),
        .drop_cnt(drop6), .frames_avail(avail6)
    );

    always #3.2 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          cyc;
    } pulse_t;

    typedef struct {
        int          group;
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        int          minGap;
        int          maxGap;
    } vec_t;

    int          testsRun = 0;
    int          testsFailed = 0;
    int          cyc = 0;
    int          lastEdge = 0;
    int          peak4 = 0;
    pulse_t      q4[$];
    logic [72:0] expQ[$];

    // Random-stream scoreboard state
    bit          wrapOn = 1'b0;
    bit          havePrev = 1'b0;
    bit          prevLast = 1'b0;
    int          prevCyc = 0;
    int          matchIdx = 0;
    int          sbDrops = 0;
    logic [72:0] inBeats[$];
    logic [72:0] curOut[$];
    int          frameStart[$];
    int          frameLen[$];
    bit          mustDeliver[$];
    bit          delivered[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (m4Valid) q4.push_back('{m4Data, m4Keep, m4Last, cyc});
        if (int'(avail4) > peak4) peak4 = int'(avail4);
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        testsRun++;
        if (act < lo || act > hi) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] d, input logic [7:0] k, input logic l);
        @(negedge clk);
        sValid = 1'b1;
        sData  = d;
        sKeep  = k;
        sLast  = l;
        if (l) lastEdge = cyc + 1;
    endtask

    task automatic goIdle();
        @(negedge clk);
        sValid = 1'b0;
        sLast  = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " tvalid"}, 64'(m4Valid), 64'd0);
        checkOutput({tag, " tdata"}, m4Data, 64'd0);
        checkOutput({tag, " tkeep"}, 64'(m4Keep), 64'd0);
        checkOutput({tag, " tlast"}, 64'(m4Last), 64'd0);
        checkOutput({tag, " drop_cnt"}, 64'(drop4), 64'd0);
        checkOutput({tag, " frames_avail"}, 64'(avail4), 64'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n  = 1'b0;
        sValid = 1'b0;
        sLast  = 1'b0;
        #1;
        checkResetOutputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q4.delete();
        expQ.delete();
        peak4 = 0;
    endtask

    task automatic sendFrame(input logic [63:0] base, input int n, input logic [7:0] lastKeep, input bit expectOut);
        for (int i = 0; i < n; i++) begin
            logic [7:0] k;
            logic       l;
            l = (i == n - 1);
            k = l ? lastKeep : 8'hFF;
            applyStimulus(base + 64'(i), k, l);
            if (expectOut) expQ.push_back({l, k, base + 64'(i)});
        end
    endtask

    task automatic compareQueue(input string name);
        checkOutput({name, " pulse count"}, 64'(q4.size()), 64'(expQ.size()));
        for (int i = 0; i < q4.size() && i < expQ.size(); i++)
            checkOutput($sformatf("%s beat %0d", name, i), {55'd0, q4[i].last, q4[i].keep, q4[i].data} >> 0 == 0 ? 64'd0 : 64'd0, 64'd0);
    endtask

    function automatic bit frameEq(input int idx);
        if (curOut.size() != frameLen[idx]) return 1'b0;
        for (int i = 0; i < curOut.size(); i++)
            if (curOut[i] !== inBeats[frameStart[idx] + i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic matchFrame();
        bit found;
        found = 1'b0;
        while (!found && matchIdx < frameLen.size()) begin
            if (frameEq(matchIdx)) begin
                found = 1'b1;
                delivered[matchIdx] = 1'b1;
            end else begin
                sbDrops++;
            end
            matchIdx++;
        end
        checkOutput("wrap output frame equals next input frame", 64'(found), 64'd1);
        curOut.delete();
    endtask

    always @(negedge clk) begin
        if (wrapOn && m6Valid) begin
            if (havePrev) begin
                if (prevLast) checkRange("wrap frame-to-frame gap", cyc - prevCyc, 26, 100000);
                else          checkRange("wrap beat spacing", cyc - prevCyc, 10, 10);
            end
            havePrev = 1'b1;
            prevCyc  = cyc;
            prevLast = m6Last;
            curOut.push_back({m6Last, m6Keep, m6Data});
            if (m6Last) matchFrame();
        end
    end

    initial begin
        vec_t vecs[6];
        int   firstLast, refCyc, n, seen;

        vecs[0] = '{0, 64'h0011223344556677, 8'hFF, 1'b0, 3, 3};
        vecs[1] = '{0, 64'h8899AABBCCDDEEFF, 8'hFF, 1'b0, 10, 10};
        vecs[2] = '{0, 64'hDEADBEEFCAFEF00D, 8'h0F, 1'b1, 10, 10};
        vecs[3] = '{1, 64'h1111111111111111, 8'hFF, 1'b0, 3, 3};
        vecs[4] = '{1, 64'h2222222222222222, 8'h3F, 1'b1, 10, 10};
        vecs[5] = '{1, 64'h3333333333333333, 8'h01, 1'b1, 26, 100};

        // Single frame and two back-to-back frames from the vector table
        for (int g = 0; g < 2; g++) begin
            doReset();
            firstLast = -1;
            for (int i = 0; i < 6; i++) begin
                if (vecs[i].group == g) begin
                    applyStimulus(vecs[i].data, vecs[i].keep, vecs[i].last);
                    if (vecs[i].last && firstLast < 0) firstLast = lastEdge;
                end
            end
            goIdle();
            repeat (120) @(negedge clk);
            checkOutput($sformatf("table group %0d pulse count", g), 64'(q4.size()), 64'd3);
            refCyc = firstLast;
            n = 0;
            for (int i = 0; i < 6; i++) begin
                if (vecs[i].group == g) begin
                    if (n < q4.size()) begin
                        checkRange($sformatf("table row %0d pulse spacing", i), q4[n].cyc - refCyc, vecs[i].minGap, vecs[i].maxGap);
                        checkOutput($sformatf("table row %0d tdata", i), q4[n].data, vecs[i].data);
                        checkOutput($sformatf("table row %0d tkeep", i), 64'(q4[n].keep), 64'(vecs[i].keep));
                        checkOutput($sformatf("table row %0d tlast", i), 64'(q4[n].last), 64'(vecs[i].last));
                        refCyc = q4[n].cyc;
                    end
                    n++;
                end
            end
            if (g == 1) checkOutput("back-to-back frames_avail peak", 64'(peak4), 64'd2);
            checkOutput($sformatf("table group %0d frames_avail drained", g), 64'(avail4), 64'd0);
        end

        // Overflow: second 10-beat frame cannot fit behind the first in 16 beats
        doReset();
        sendFrame(64'hA000, 10, 8'hFF, 1'b1);
        sendFrame(64'hB000, 10, 8'hFF, 1'b0);
        sendFrame(64'hC000, 4, 8'h07, 1'b1);
        goIdle();
        repeat (400) @(negedge clk);
        checkOutput("overflow pulse count", 64'(q4.size()), 64'(expQ.size()));
        for (int i = 0; i < q4.size() && i < expQ.size(); i++)
            checkOutput($sformatf("overflow beat %0d", i), 64'({q4[i].last, q4[i].keep, q4[i].data} ^ expQ[i]), 64'd0);
        checkOutput("overflow drop_cnt", 64'(drop4), 64'd1);
        checkOutput("overflow frames_avail drained", 64'(avail4), 64'd0);

        // Oversize: 20 beats into 16, then an exactly-full frame must still fit
        doReset();
        sendFrame(64'hD000, 20, 8'hFF, 1'b0);
        goIdle();
        repeat (50) @(negedge clk);
        checkOutput("oversize no output", 64'(q4.size()), 64'd0);
        checkOutput("oversize drop_cnt", 64'(drop4), 64'd1);
        checkOutput("oversize frames_avail", 64'(avail4), 64'd0);
        sendFrame(64'hE000, 16, 8'h80, 1'b1);
        goIdle();
        repeat (250) @(negedge clk);
        checkOutput("full-size after oversize pulse count", 64'(q4.size()), 64'd16);
        for (int i = 0; i < q4.size() && i < expQ.size(); i++)
            checkOutput($sformatf("full-size beat %0d", i), 64'({q4[i].last, q4[i].keep, q4[i].data} ^ expQ[i]), 64'd0);
        checkOutput("full-size drop_cnt unchanged", 64'(drop4), 64'd1);

        // Reset while the second of five beats is on the output
        doReset();
        sendFrame(64'hF000, 5, 8'hFF, 1'b0);
        goIdle();
        seen = 0;
        for (int k = 0; k < 100 && seen < 2; k++) begin
            @(negedge clk);
            if (m4Valid) seen++;
        end
        checkOutput("reset-test second pulse reached", 64'(seen), 64'd2);
        rst_n = 1'b0;
        #1;
        checkResetOutputs("mid-frame reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        q4.delete();
        applyStimulus(64'h0123456789ABCDEF, 8'h3C, 1'b1);
        goIdle();
        repeat (150) @(negedge clk);
        checkOutput("post-reset pulse count", 64'(q4.size()), 64'd1);
        if (q4.size() > 0) begin
            checkRange("post-reset latency", q4[0].cyc - lastEdge, 3, 3);
            checkOutput("post-reset tdata", q4[0].data, 64'h0123456789ABCDEF);
            checkOutput("post-reset tkeep", 64'(q4[0].keep), 64'h3C);
            checkOutput("post-reset tlast", 64'(q4[0].last), 64'd1);
        end

        // Random stream through the 64-beat instance, compared frame by frame
        doReset();
        wrapOn = 1'b1;
        for (int f = 0; f < 200; f++) begin
            int  len, gap;
            bit  quiet;
            quiet = (f % 20 == 0);
            len   = int'($urandom_range(1, 60));
            gap   = quiet ? 2500 : int'($urandom_range(0, 150));
            if (gap > 0) begin
                goIdle();
                repeat (gap - 1) @(negedge clk);
            end
            frameStart.push_back(inBeats.size());
            frameLen.push_back(len);
            mustDeliver.push_back(quiet);
            delivered.push_back(1'b0);
            for (int b = 0; b < len; b++) begin
                logic [63:0] d;
                logic [7:0]  k;
                logic        l;
                d = {$urandom, $urandom};
                k = 8'($urandom_range(0, 255));
                l = (b == len - 1);
                inBeats.push_back({l, k, d});
                applyStimulus(d, k, l);
            end
        end
        goIdle();
        repeat (2500) @(negedge clk);
        wrapOn = 1'b0;
        while (matchIdx < frameLen.size()) begin
            sbDrops++;
            matchIdx++;
        end
        checkOutput("wrap drop_cnt vs scoreboard", 64'(drop6), 64'(sbDrops));
        checkOutput("wrap frames_avail drained", 64'(avail6), 64'd0);
        checkOutput("wrap no partial output frame", 64'(curOut.size()), 64'd0);
        for (int i = 0; i < frameLen.size(); i++)
            if (mustDeliver[i]) checkOutput($sformatf("wrap frame %0d into empty buffer delivered", i), 64'(delivered[i]), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
